// File: rtl/instr_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// instr_fetch_arbiter
//
// Shares one byte-wide instruction memory between an instruction fetch port
// and a program-load (byte write) port. Fetches read four consecutive bytes
// and assemble a big-endian 32-bit word; loads write a single byte.
// Conflicting requests in IDLE are resolved round-robin (fetch first after
// reset).
//
// Parameters
//   INSTR_NUM      instruction memory size in bytes
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   fetch_valid_i  fetch request valid
//   fetch_addr_i   fetch byte address (word base)
//   fetch_ready_o  fetch accepted this cycle
//   instr_o        last assembled instruction word (held between responses)
//   instr_valid_o  one-cycle response pulse
//   fetch_err_o    response error flag, qualified by instr_valid_o
//   load_valid_i   load request valid
//   load_addr_i    load byte address
//   load_data_i    load byte data
//   load_ready_o   load accepted this cycle
//   mem_addr_o     shared memory byte address
//   mem_we_o       memory byte write enable
//   mem_wdata_o    memory byte write data
//   mem_rdata_i    memory byte read data (combinational from mem_addr_o)
//
// Configuration
//   FETCH_ALIGN_CHECK_EN  when defined, fetches with addr[1:0] != 0 return an
//                         error response without touching memory.
// -----------------------------------------------------------------------------
module instr_fetch_arbiter #(
    parameter int INSTR_NUM = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_ready_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        fetch_err_o,
    input  logic        load_valid_i,
    input  logic [31:0] load_addr_i,
    input  logic [7:0]  load_data_i,
    output logic        load_ready_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    // Highest legal word base; anything above would read past the end.
    localparam logic [31:0] FETCH_MAX = 32'(INSTR_NUM - 4);
    localparam logic [31:0] LOAD_LIM  = 32'(INSTR_NUM);

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [7:0]  data_q;
    logic [1:0]  cnt;
    logic [23:0] word;       // first three bytes; the fourth joins on the last RD cycle
    logic [31:0] instr_q;
    logic        err_q;
    logic        we_ok;      // latched load address was in range
    logic        prio_load;  // load wins the next conflict

    logic idle;
    logic grant_fetch;
    logic grant_load;
    logic fetch_bad;

    assign idle = (state == IDLE);

    // Ready is combinational so a valid in IDLE transfers on the same edge;
    // gated by reset so nothing is accepted on a reset edge.
    assign grant_fetch = idle && !rst_i && fetch_valid_i && (!load_valid_i || !prio_load);
    assign grant_load  = idle && !rst_i && load_valid_i  && (!fetch_valid_i || prio_load);

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_bad = (fetch_addr_i > FETCH_MAX) || (fetch_addr_i[1:0] != 2'b00);
`else
    assign fetch_bad = (fetch_addr_i > FETCH_MAX);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            cnt       <= '0;
            word      <= '0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            we_ok     <= 1'b0;
            prio_load <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fetch) begin
                        addr_q    <= fetch_addr_i;
                        cnt       <= '0;
                        prio_load <= 1'b1;
                        if (fetch_bad) begin
                            // instr_o changes here so the error response shows 0.
                            err_q   <= 1'b1;
                            instr_q <= '0;
                            state   <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            state   <= RD;
                        end
                    end else if (grant_load) begin
                        addr_q    <= load_addr_i;
                        data_q    <= load_data_i;
                        we_ok     <= (load_addr_i < LOAD_LIM);
                        prio_load <= 1'b0;
                        state     <= WR;
                    end
                end
                RD: begin
                    word <= {word[15:0], mem_rdata_i};
                    cnt  <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        instr_q <= {word, mem_rdata_i};
                        state   <= RESP;
                    end
                end
                WR:      state <= IDLE;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fetch_ready_o = grant_fetch;
    assign load_ready_o  = grant_load;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state == RESP);
    assign fetch_err_o   = (state == RESP) && err_q;

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (state)
            RD: mem_addr_o = addr_q + {30'd0, cnt};
            WR: begin
                mem_addr_o  = addr_q;
                mem_wdata_o = data_q;
                mem_we_o    = we_ok;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
module tb_instr_fetch_arbiter;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;
    logic        load_valid = 1'b0;
    logic [31:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        load_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    instr_fetch_arbiter #(.INSTR_NUM(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fetch_valid), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready),
        .instr_o(instr), .instr_valid_o(instr_valid), .fetch_err_o(fetch_err),
        .load_valid_i(load_valid), .load_addr_i(load_addr), .load_data_i(load_data),
        .load_ready_o(load_ready),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Physical memory attached to the DUT.
    logic [7:0] tb_mem [0:N-1];
    always_comb mem_rdata = (mem_addr < 32'(N)) ? tb_mem[mem_addr[9:0]] : 8'h00;
    always @(posedge clk) if (mem_we && mem_addr < 32'(N)) tb_mem[mem_addr[9:0]] <= mem_wdata;

    // Reference model: byte image, round-robin owner, last response word.
    logic [7:0]  ref_mem [0:N-1];
    bit          m_prio_load;
    logic [31:0] m_instr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit fetch_is_err(input logic [31:0] a);
        bit e;
        e = a > 32'(N - 4);
`ifdef FETCH_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a[9:0]], ref_mem[10'(a + 1)], ref_mem[10'(a + 2)], ref_mem[10'(a + 3)]};
    endfunction

    // One arbitration round: present requests in IDLE, then follow the
    // granted operation to completion checking every cycle.
    task automatic op(input bit fv, input logic [31:0] fa, input bit lv,
                      input logic [31:0] la, input logic [7:0] ld, input bit drop);
        bit gf, gl;
        logic [31:0] exp_w;
        @(negedge clk);
        fetch_valid = fv; fetch_addr = fa;
        load_valid = lv; load_addr = la; load_data = ld;
        gf = fv && (!lv || !m_prio_load);
        gl = lv && (!fv || m_prio_load);
        #1;
        chk("fetch_ready", 32'(fetch_ready), 32'(gf));
        chk("load_ready", 32'(load_ready), 32'(gl));
        chk("idle_addr", mem_addr, 32'h0);
        chk("idle_we", 32'(mem_we), 32'h0);
        if (drop) begin
            #2;
            fetch_valid = 1'b0; load_valid = 1'b0;
            gf = 1'b0; gl = 1'b0;
        end
        @(negedge clk);
        fetch_valid = 1'b0; load_valid = 1'b0;
        if (gf) begin
            m_prio_load = 1'b1;
            if (fetch_is_err(fa)) begin
                #1;
                chk("err_valid", 32'(instr_valid), 32'h1);
                chk("err_flag", 32'(fetch_err), 32'h1);
                chk("err_instr", instr, 32'h0);
                chk("err_addr", mem_addr, 32'h0);
                m_instr = 32'h0;
            end else begin
                exp_w = ref_word(fa);
                for (int k = 0; k < 4; k++) begin
                    fetch_valid = 1'b1; load_valid = 1'b1;
                    #1;
                    chk("rd_addr", mem_addr, fa + 32'(k));
                    chk("rd_we", 32'(mem_we), 32'h0);
                    chk("rd_readies", {30'd0, fetch_ready, load_ready}, 32'h0);
                    chk("rd_valid", 32'(instr_valid), 32'h0);
                    chk("rd_hold", instr, m_instr);
                    @(negedge clk);
                end
                fetch_valid = 1'b0; load_valid = 1'b0;
                #1;
                chk("resp_valid", 32'(instr_valid), 32'h1);
                chk("resp_err", 32'(fetch_err), 32'h0);
                chk("resp_instr", instr, exp_w);
                chk("resp_addr", mem_addr, 32'h0);
                m_instr = exp_w;
            end
        end else if (gl) begin
            fetch_valid = 1'b1; load_valid = 1'b1;
            #1;
            chk("wr_we", 32'(mem_we), 32'(la < 32'(N)));
            chk("wr_addr", mem_addr, la);
            chk("wr_data", 32'(mem_wdata), 32'(ld));
            chk("wr_readies", {30'd0, fetch_ready, load_ready}, 32'h0);
            if (la < 32'(N)) ref_mem[la[9:0]] = ld;
            m_prio_load = 1'b0;
            @(negedge clk);
            fetch_valid = 1'b0; load_valid = 1'b0;
            #1;
            chk("post_wr_we", 32'(mem_we), 32'h0);
            chk("post_wr_valid", 32'(instr_valid), 32'h0);
            chk("post_wr_hold", instr, m_instr);
        end else begin
            #1;
            chk("none_valid", 32'(instr_valid), 32'h0);
            chk("none_we", 32'(mem_we), 32'h0);
            chk("none_hold", instr, m_instr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; fetch_valid = 1'b1; load_valid = 1'b1;
        #1;
        chk("rst_readies", {30'd0, fetch_ready, load_ready}, 32'h0);
        @(negedge clk);
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        chk("rst_mem", {mem_addr[23:0], mem_wdata}, 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        rst = 1'b0; fetch_valid = 1'b0; load_valid = 1'b0;
        m_prio_load = 1'b0;
        m_instr = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fv, lv, dr;
        logic [31:0] fa, la;
        for (int i = 0; i < N; i++) begin
            tb_mem[i] = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        do_reset();

        // Program load then fetch of a known word.
        op(1'b0, 0, 1'b1, 32'h10, 8'h8C, 1'b0);
        op(1'b0, 0, 1'b1, 32'h11, 8'h01, 1'b0);
        op(1'b0, 0, 1'b1, 32'h12, 8'h00, 1'b0);
        op(1'b0, 0, 1'b1, 32'h13, 8'h04, 1'b0);
        op(1'b1, 32'h10, 1'b0, 0, 8'h00, 1'b0);
        chk("known_word", instr, 32'h8C010004);

        // Round-robin after reset: fetch, load, fetch.
        do_reset();
        op(1'b1, 32'h10, 1'b1, 32'h30, 8'h55, 1'b0);
        op(1'b1, 32'h14, 1'b1, 32'h31, 8'h66, 1'b0);
        op(1'b1, 32'h30, 1'b1, 32'h32, 8'h77, 1'b0);

        // Range boundaries.
        op(1'b1, 32'h3FD, 1'b0, 0, 8'h00, 1'b0);
        op(1'b1, 32'h3FC, 1'b0, 0, 8'h00, 1'b0);
        op(1'b1, 32'hFFFF_FFFC, 1'b0, 0, 8'h00, 1'b0);
        op(1'b0, 0, 1'b1, 32'h20, 8'hA5, 1'b0);
        op(1'b0, 0, 1'b1, 32'h400, 8'h5A, 1'b0);
        op(1'b0, 0, 1'b1, 32'h3FF, 8'h3C, 1'b0);

        // Unaligned fetch: error with the alignment check, normal otherwise.
        op(1'b1, 32'h11, 1'b0, 0, 8'h00, 1'b0);

        // Withdrawn request.
        op(1'b1, 32'h10, 1'b1, 32'h40, 8'h99, 1'b1);

        // Reset during the third RD cycle aborts the fetch.
        @(negedge clk);
        fetch_valid = 1'b1; fetch_addr = 32'h10; load_valid = 1'b0;
        #1;
        chk("abort_accept", 32'(fetch_ready), 32'h1);
        @(negedge clk);
        fetch_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_rd1_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rd2_addr", mem_addr, 32'h12);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(instr_valid), 32'h0);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_instr", instr, 32'h0);
        fetch_valid = 1'b1; load_valid = 1'b1;
        #1;
        chk("abort_fready", 32'(fetch_ready), 32'h1);
        chk("abort_lready", 32'(load_ready), 32'h0);
        #2;
        fetch_valid = 1'b0; load_valid = 1'b0;
        m_prio_load = 1'b0;
        m_instr = 32'h0;
        @(negedge clk);
        #1;
        chk("abort_no_pulse", 32'(instr_valid), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: fa = 32'($urandom_range(0, N - 1));
                1: fa = 32'(N - 12 + int'($urandom_range(0, 15)));
                2: fa = $urandom;
                default: fa = 32'($urandom_range(0, 255)) << 2;
            endcase
            la = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, N + 7));
            fv = ($urandom_range(0, 1) == 1);
            lv = ($urandom_range(0, 1) == 1);
            dr = ($urandom_range(0, 9) == 0);
            op(fv, fa, lv, la, 8'($urandom), dr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
